// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the multiplier arbiter slice.
//
// Contents:
//   MulW         default operand/result width of the shared multiplier
//   arb_state_e  arbiter FSM state encoding (StArb / StIssue / StWait)
//   wrap_inc     modulo-N increment used for the round-robin pointer

package mul_pkg;

  localparam int unsigned MulW = 32;

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  // Returns (idx + 1) mod n without a divider.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational N-way round-robin selector.
//
// Picks the first asserted request bit at or above the pointer, wrapping
// modulo N. Purely combinational so it can be dropped into any arbiter.
//
// Ports:
//   i_req        N-bit request vector
//   i_ptr        priority pointer; i_req[i_ptr] has highest priority
//   o_grant      index of the selected requester (equals i_ptr when none)
//   o_any_valid  high when at least one request bit is set

module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_grant,
  output logic           o_any_valid
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    o_grant     = i_ptr;
    o_any_valid = 1'b0;
    w_idx       = '0;
    // Scan offsets 0..N-1 from the pointer; the first hit is kept.
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IDW'((32'(i_ptr) + k) % N);
      if (!o_any_valid && i_req[w_idx]) begin
        o_grant     = w_idx;
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one iterative multiplier among
// N requesters, with exactly one operation outstanding at a time.
//
// Flow: StArb grants one requester and latches its operands, StIssue presents
// them to the multiplier, StWait routes the multiplier result back to the
// granted requester only. The round-robin pointer moves past the owner only
// once its response has been handed over.
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   req_val/req_rdy/req_a/req_b       per-requester operand streams (packed)
//   resp_val/resp_rdy/resp_result     per-requester result streams
//                                     (resp_result shared, pass-through)
//   mul_istream_val/rdy, mul_a/mul_b  operand stream to the multiplier
//   mul_ostream_val/rdy, mul_result   result stream from the multiplier
//   busy                              high outside the arbitration state
//   owner                             index of the current/last grant

module mul_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = MulW,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [N-1:0]     req_val,
  output logic [N-1:0]     req_rdy,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,

  output logic [N-1:0]     resp_val,
  input  logic [N-1:0]     resp_rdy,
  output logic [W-1:0]     resp_result,

  output logic             mul_istream_val,
  input  logic             mul_istream_rdy,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,

  input  logic             mul_ostream_val,
  output logic             mul_ostream_rdy,
  input  logic [W-1:0]     mul_result,

  output logic             busy,
  output logic [IDW-1:0]   owner
);

  arb_state_e     r_state;
  arb_state_e     w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_owner;
  logic [W-1:0]   r_mul_a;
  logic [W-1:0]   r_mul_b;

  logic [IDW-1:0] w_grant;
  logic           w_any_valid;
  logic           w_req_fire;
  logic           w_resp_fire;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .i_req       (req_val),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_any_valid (w_any_valid)
  );

  assign w_req_fire  = (r_state == StArb) && w_any_valid;
  assign w_resp_fire = (r_state == StWait) && mul_ostream_val && resp_rdy[r_owner];

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next    = r_state;
    req_rdy         = '0;
    resp_val        = '0;
    mul_istream_val = 1'b0;
    mul_ostream_rdy = 1'b0;

    unique case (r_state)
      StArb: begin
        if (w_any_valid) begin
          req_rdy[w_grant] = 1'b1;
          w_state_next     = StIssue;
        end
      end
      StIssue: begin
        mul_istream_val = 1'b1;
        if (mul_istream_rdy) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        // Only the owner sees the result; other resp_rdy bits are ignored.
        resp_val[r_owner] = mul_ostream_val;
        mul_ostream_rdy   = resp_rdy[r_owner];
        if (w_resp_fire) begin
          w_state_next = StArb;
        end
      end
      default: begin
        w_state_next = StArb;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StArb;
      r_ptr   <= '0;
      r_owner <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      r_state <= w_state_next;
      // Operands are captured only on the request handshake.
      if (w_req_fire) begin
        r_owner <= w_grant;
        r_mul_a <= req_a[w_grant*W +: W];
        r_mul_b <= req_b[w_grant*W +: W];
      end
      // Pointer moves on completion so the served requester drops to lowest priority.
      if (w_resp_fire) begin
        r_ptr <= IDW'(wrap_inc(32'(r_owner), N));
      end
    end
  end

  assign resp_result = mul_result;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign busy        = (r_state != StArb);
  assign owner       = r_owner;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  localparam int unsigned N      = 4;
  localparam int unsigned W      = 32;
  localparam int unsigned IDW    = 2;
  localparam int unsigned MulLat = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_val;
  logic [N-1:0]   req_rdy;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   resp_val;
  logic [N-1:0]   resp_rdy;
  logic [W-1:0]   resp_result;
  logic           mul_istream_val;
  logic           mul_istream_rdy;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_ostream_val;
  logic           mul_ostream_rdy;
  logic [W-1:0]   mul_result;
  logic           busy;
  logic [IDW-1:0] owner;

  always #5 clk = ~clk;

  mul_arbiter #(
    .N   (N),
    .W   (W),
    .IDW (IDW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_val         (req_val),
    .req_rdy         (req_rdy),
    .req_a           (req_a),
    .req_b           (req_b),
    .resp_val        (resp_val),
    .resp_rdy        (resp_rdy),
    .resp_result     (resp_result),
    .mul_istream_val (mul_istream_val),
    .mul_istream_rdy (mul_istream_rdy),
    .mul_a           (mul_a),
    .mul_b           (mul_b),
    .mul_ostream_val (mul_ostream_val),
    .mul_ostream_rdy (mul_ostream_rdy),
    .mul_result      (mul_result),
    .busy            (busy),
    .owner           (owner)
  );

  // Iterative multiplier stand-in: accepts when idle, answers MulLat cycles later.
  logic         m_busy;
  logic         m_oval;
  int           m_cnt;
  logic [W-1:0] m_prod;

  assign mul_istream_rdy = !m_busy;
  assign mul_ostream_val = m_oval;
  assign mul_result      = m_prod;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_oval <= 1'b0;
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (!m_busy && mul_istream_val) begin
      m_busy <= 1'b1;
      m_cnt  <= MulLat;
      m_prod <= mul_a * mul_b;
    end else if (m_busy && !m_oval) begin
      if (m_cnt == 1) m_oval <= 1'b1;
      m_cnt <= m_cnt - 1;
    end else if (m_oval && mul_ostream_rdy) begin
      m_oval <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Transaction-level reference model.
  logic         started = 1'b0;
  bit           s_free  = 1'b1;   // no operation outstanding
  bit           s_issue = 1'b0;   // operands waiting for the multiplier
  bit           s_wait  = 1'b0;   // operation accepted, awaiting result
  int           s_ptr   = 0;
  int           s_owner = 0;
  logic [W-1:0] s_a, s_b;
  int           n_done  = 0;
  int           grants[$];
  logic [W-1:0] last_res[N];

  always @(posedge clk) if (!rst) started <= 1'b1;

  function automatic int pick(input logic [N-1:0] v, input int p);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    int g;
    if (started) begin
      exp_rdy = '0;
      exp_rv  = '0;
      g       = -1;
      if (s_free) begin
        g = pick(req_val, s_ptr);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      if (s_wait && mul_ostream_val) exp_rv[s_owner] = 1'b1;
      chk("req_rdy", W'(req_rdy), W'(exp_rdy));
      chk("resp_val", W'(resp_val), W'(exp_rv));
      chk("busy", W'(busy), W'(!s_free));
      chk("owner", W'(owner), W'(s_owner));
      chk("istream_val", W'(mul_istream_val), W'(s_issue));
      chk("ostream_rdy", W'(mul_ostream_rdy), W'(s_wait ? resp_rdy[s_owner] : 1'b0));
      chk("resp_result_pass", resp_result, mul_result);
      if (s_issue) begin
        chk("mul_a", mul_a, s_a);
        chk("mul_b", mul_b, s_b);
      end
      // Advance the model to what the coming edge does.
      if (!rst) begin
        s_free  = 1'b1;
        s_issue = 1'b0;
        s_wait  = 1'b0;
        s_ptr   = 0;
        s_owner = 0;
      end else if (g >= 0) begin
        s_free  = 1'b0;
        s_issue = 1'b1;
        s_owner = g;
        s_a     = req_a[g*W +: W];
        s_b     = req_b[g*W +: W];
        grants.push_back(g);
      end else if (s_issue && mul_istream_rdy) begin
        s_issue = 1'b0;
        s_wait  = 1'b1;
      end else if (s_wait && mul_ostream_val && resp_rdy[s_owner]) begin
        chk("product", resp_result, s_a * s_b);
        last_res[s_owner] = resp_result;
        s_wait = 1'b0;
        s_free = 1'b1;
        s_ptr  = (s_owner + 1) % N;
        n_done++;
      end
    end
  end

  task automatic wait_accept(input int idx, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_rdy[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
    @(posedge clk); #1;
    req_val[idx] = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // Drops each requester's valid after its handshake until target completions.
  task automatic serve(input int target, input string name);
    logic [N-1:0] acc;
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      acc = req_rdy & req_val;
      @(posedge clk); #1;
      req_val = req_val & ~acc;
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc;
    int base;
    bit ok;

    rst      = 1'b0;
    req_val  = '0;
    req_a    = '0;
    req_b    = '0;
    resp_rdy = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", W'(req_rdy), '0);
    chk("rst_resp_val", W'(resp_val), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_owner", W'(owner), '0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    chk("rst_istream_val", W'(mul_istream_val), '0);
    chk("rst_ostream_rdy", W'(mul_ostream_rdy), '0);

    // All requesters valid continuously from reset.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom_range(1, 5000);
      req_b[i*W +: W] = $urandom_range(1, 5000);
    end
    req_val = '1;
    @(posedge clk); #1;
    rst = 1'b1;
    ok  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_rdy & req_val;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_a[i*W +: W] = $urandom;
          req_b[i*W +: W] = $urandom;
        end
      end
      if (n_done >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    req_val = '0;
    if (!ok) timeout("all_valid");
    chk("grant_count", W'(grants.size() >= 5), W'(1));
    if (grants.size() >= 5) begin
      chk("grant_order0", W'(grants[0]), 0);
      chk("grant_order1", W'(grants[1]), 1);
      chk("grant_order2", W'(grants[2]), 2);
      chk("grant_order3", W'(grants[3]), 3);
      chk("grant_order4", W'(grants[4]), 0);
    end

    // Single request: 7 * 6 from requester 2.
    base = n_done;
    req_a[2*W +: W] = 7;
    req_b[2*W +: W] = 6;
    req_val[2] = 1'b1;
    @(negedge clk);
    chk("single_req_rdy", W'(req_rdy), W'(4'b0100));
    @(posedge clk); #1;
    req_val[2] = 1'b0;
    @(negedge clk);
    chk("single_issue", W'(mul_istream_val), W'(1));
    chk("single_mul_a", mul_a, 7);
    chk("single_mul_b", mul_b, 6);
    chk("single_no_rdy", W'(req_rdy), '0);
    wait_done(base + 1, "single_done");
    chk("single_result", last_res[2], 42);

    // Operand change after accept: 3 * 5, then req_a[1] becomes 9.
    base = n_done;
    req_a[1*W +: W] = 3;
    req_b[1*W +: W] = 5;
    req_val[1] = 1'b1;
    wait_accept(1, "latch_accept");
    req_a[1*W +: W] = 9;
    wait_done(base + 1, "latch_done");
    chk("latch_result", last_res[1], 15);

    // Fairness: after serving 3, requesters 0 and 3 compete -> 0 wins.
    base = n_done;
    req_a[3*W +: W] = 11;
    req_b[3*W +: W] = 13;
    req_val[3] = 1'b1;
    wait_accept(3, "fair_accept3");
    wait_done(base + 1, "fair_done3");
    chk("fair_result3", last_res[3], 143);
    req_a[0*W +: W] = 100;
    req_b[0*W +: W] = 200;
    req_val[0] = 1'b1;
    req_val[3] = 1'b1;
    @(negedge clk);
    chk("fair_grant", W'(req_rdy), W'(4'b0001));
    @(posedge clk); #1;
    req_val[0] = 1'b0;
    serve(base + 3, "fair_serve");
    chk("fair_result0", last_res[0], 20000);

    // Backpressure on the owner's resp_rdy.
    base = n_done;
    resp_rdy = '0;
    req_a[0*W +: W] = 21;
    req_b[0*W +: W] = 2;
    req_val[0] = 1'b1;
    wait_accept(0, "bp_accept");
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (resp_val[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("bp_resp_val");
    @(posedge clk); #1;
    req_val[1] = 1'b1;
    req_val[2] = 1'b1;
    resp_rdy   = 4'b1110;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_busy", W'(busy), W'(1));
      chk("bp_resp_val", W'(resp_val), W'(4'b0001));
      chk("bp_ostream_rdy", W'(mul_ostream_rdy), '0);
      chk("bp_req_rdy", W'(req_rdy), '0);
      chk("bp_result", resp_result, 42);
    end
    @(posedge clk); #1;
    resp_rdy = '1;
    serve(base + 3, "bp_serve");

    // Reset in the middle of an operation.
    base = n_done;
    req_val[1] = 1'b1;
    wait_accept(1, "rst_pre_accept");
    wait_done(base + 1, "rst_pre_done");
    req_val[2] = 1'b1;
    wait_accept(2, "rst_mid_accept");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", W'(busy), '0);
    chk("rst_mid_req_rdy", W'(req_rdy), '0);
    chk("rst_mid_resp_val", W'(resp_val), '0);
    chk("rst_mid_owner", W'(owner), '0);
    base = n_done;
    @(posedge clk); #1;
    req_a[3*W +: W] = 4;
    req_b[3*W +: W] = 8;
    req_val = 4'b1010;
    @(negedge clk);
    chk("rst_ptr_grant", W'(req_rdy), W'(4'b0010));
    @(posedge clk); #1;
    req_val[1] = 1'b0;
    serve(base + 2, "rst_post_serve");
    chk("rst_post_result3", last_res[3], 32);

    // Randomised traffic.
    base = n_done;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = req_rdy & req_val;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_val[i] = 1'b0;
          req_a[i*W +: W] = $urandom;
        end else if (!req_val[i] && $urandom_range(0, 3) == 0) begin
          req_val[i] = 1'b1;
          req_a[i*W +: W] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 255);
          req_b[i*W +: W] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 255);
        end
      end
      resp_rdy = N'($urandom);
    end
    resp_rdy = '1;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      acc = req_rdy & req_val;
      @(posedge clk); #1;
      req_val = req_val & ~acc;
      if (req_val == '0 && s_free) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("random_drain");
    chk("random_progress", W'(n_done - base > 10), W'(1));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
